row_sum_accumulator: RTL
========================

Name: row_sum_accumulator

Overview:
- Stage directly downstream of the per-channel multiplier.
- Consumes NUM_CHANNELS 32-bit products per beat, reduces them with a registered adder tree, and accumulates across beats until the row-last beat.
- Each finished row sum, tagged with its row index, goes into a first-word-fall-through output FIFO drained by a valid/ready handshake.
- Provides upstream back-pressure (stall) and a sticky overflow flag.

Parameters:
- NUM_CHANNELS, 4: product lanes per beat.
- FIFO_DEPTH, 8: output FIFO entries; power of 2, >= 4.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  reset; asynchronous assert, active-low.
- clear  in  1  synchronous flush: pipeline, accumulator, row counter, FIFO, overflow.
- multiplied_values  in  NUM_CHANNELS x 32  product per lane, packed [NUM_CHANNELS-1:0][31:0].
- lane_mask  in  NUM_CHANNELS  1 = lane holds a valid product; masked lanes contribute 0.
- row_last  in  1  beat is the final beat of the current row.
- rdy_in  in  1  single-cycle beat strobe from multiplier; data, lane_mask and row_last are valid only with it.
- stall  out  1  upstream must not assert rdy_in while high.
- row_sum  out  32  FIFO head: row sum.
- row_index  out  32  FIFO head: row number, 0-based.
- sum_valid  out  1  FIFO non-empty.
- sum_ready  in  1  consumer pops head when sum_valid && sum_ready.
- overflow  out  1  sticky; a row result was dropped.

Behaviour:
- Reset (rst_l low, asynchronous) and clear (synchronous, overrides all other activity in that cycle) force all outputs low/zero: sum_valid=0, stall=0, overflow=0, row_sum=0, row_index=0. They also reset the accumulator, row counter, FIFO pointers and pipeline valids to 0.
- Reset or clear mid-row discards the partial sum and any in-flight beats.
- Arithmetic: unsigned/two's-complement 32-bit integer. All additions wrap modulo 2^32; no saturation and no carry out.
- S1 (edge after rdy_in): lane_sum <= sum over k of (lane_mask[k] ? multiplied_values[k] : 0). row_last is carried alongside; s1_valid <= rdy_in.
- S2 (next edge, if s1_valid):
  - If row_last = 0: acc <= acc + lane_sum.
  - If row_last = 1: push {acc + lane_sum, row_cnt} into the FIFO, then acc <= 0 and row_cnt <= row_cnt + 1.
- Latency: rdy_in sampled at edge E0 on a row_last beat into an empty FIFO gives sum_valid=1 with that result on row_sum/row_index after edge E2.
- Back-to-back rdy_in every cycle is supported at full throughput.
- Empty row: row_last with lane_mask=0 pushes the current acc; a single-beat all-masked row pushes 0.
- FIFO is first-word-fall-through: row_sum/row_index always show the head and are stable while sum_valid && !sum_ready.
- Pop occurs on sum_valid && sum_ready.
- Push when full:
  - With a pop in the same cycle: push is accepted and occupancy is unchanged.
  - Without a pop: result is dropped, overflow <= 1 (sticky until reset/clear), row_cnt still increments so later indices stay aligned.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter is 0..FIFO_DEPTH.
- stall = (free entries <= 2), registered from the occupancy counter. This covers the two beats possibly in flight in S1/S2.
- rdy_in while stall=1 is a protocol violation. It is not checked, except that a resulting full-FIFO drop sets overflow.
- No FSM beyond pipeline valids and FIFO control; the accumulator and row counter are the only persistent state.

Test Plan:
- Reset: rst_l low mid-row with acc=50 → all outputs 0 immediately. After release, a 1-beat row {1,2,3,4}, mask 1111, last → row_sum=10, row_index=0, sum_valid exactly 2 edges after rdy_in.
- Multi-beat with mask:
  - Row 0: beats {1,1,1,1}/1111, {5,6,7,8}/0011 last → 2 edges later row_sum=15, row_index=0.
  - Row 1: {0xFFFFFFFF,2,0,0}/0011 last → row_sum=1 (wrap), row_index=1.
- Back-to-back: 10 single-beat rows, rdy_in every cycle, each lane = row number r, mask 1111, sum_ready=1 → sums 4r, indices 0..9 in order, no gaps, overflow=0.
- Back-pressure: sum_ready=0, FIFO_DEPTH=8, issue rows honouring stall → stall rises when occupancy reaches 6. Head holds row 0 stable. Releasing sum_ready drains all rows in order.
- Overflow: sum_ready=0, ignore stall, push 9 rows → 9th dropped, overflow=1, 8 entries held (indices 0..7). Next row after draining is tagged index 9.
- Clear: assert clear with 3 entries queued and a partial acc=7 → sum_valid=0, overflow=0, stall=0. Next row {2,2,2,2} last gives row_sum=8, row_index=0.

Source files
------------

// File: rtl/row_sum_accumulator.sv
// Row-sum stage: masks and reduces per-lane products, accumulates beats into row
// sums and queues {sum, row index} in a first-word-fall-through FIFO.
module row_sum_accumulator #(
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         clear,
  input  logic [NUM_CHANNELS-1:0][31:0] multiplied_values,
  input  logic [NUM_CHANNELS-1:0]      lane_mask,
  input  logic                         row_last,
  input  logic                         rdy_in,
  output logic                         stall,
  output logic [31:0]                  row_sum,
  output logic [31:0]                  row_index,
  output logic                         sum_valid,
  input  logic                         sum_ready,
  output logic                         overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   lane_sum_s;
  logic [31:0]   s1_sum_r;
  logic          s1_last_r;
  logic          s1_valid_r;
  logic [31:0]   acc_r;
  logic [31:0]   row_cnt_r;
  logic          push_valid_r;
  logic [31:0]   push_sum_r;
  logic [31:0]   push_idx_r;
  logic [31:0]   mem_sum [FIFO_DEPTH];
  logic [31:0]   mem_idx [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s;
  logic          full_s;
  logic          accept_s;
  logic          drop_s;
  logic [PW-1:0] next_rd_s;
  logic [CW-1:0] count_next_s;
  logic          stall_next_s;
  logic          bypass_s;
  logic [31:0]   head_sum_s;
  logic [31:0]   head_idx_s;

  // Masked lane reduction; all sums wrap modulo 2^32.
  always_comb begin
    lane_sum_s = 32'd0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (lane_mask[k]) begin
        lane_sum_s = lane_sum_s + multiplied_values[k];
      end else begin
        lane_sum_s = lane_sum_s;
      end
    end
  end

  // S1: register the reduced beat and its row_last tag.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_sum_r   <= 32'd0;
    end else if (clear) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_sum_r   <= 32'd0;
    end else begin
      s1_valid_r <= rdy_in;
      if (rdy_in) begin
        s1_last_r <= row_last;
        s1_sum_r  <= lane_sum_s;
      end
    end
  end

  // S2: accumulate, or close the row into the push register; the row counter
  // advances even if the FIFO later drops the result.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      acc_r        <= 32'd0;
      row_cnt_r    <= 32'd0;
      push_valid_r <= 1'b0;
      push_sum_r   <= 32'd0;
      push_idx_r   <= 32'd0;
    end else if (clear) begin
      acc_r        <= 32'd0;
      row_cnt_r    <= 32'd0;
      push_valid_r <= 1'b0;
      push_sum_r   <= 32'd0;
      push_idx_r   <= 32'd0;
    end else begin
      push_valid_r <= s1_valid_r && s1_last_r;
      if (s1_valid_r) begin
        if (s1_last_r) begin
          push_sum_r <= acc_r + s1_sum_r;
          push_idx_r <= row_cnt_r;
          acc_r      <= 32'd0;
          row_cnt_r  <= row_cnt_r + 32'd1;
        end else begin
          acc_r <= acc_r + s1_sum_r;
        end
      end
    end
  end

  assign pop_s     = sum_valid && sum_ready;
  assign full_s    = (count_r == CW'(FIFO_DEPTH));
  assign accept_s  = push_valid_r && (!full_s || pop_s) && !clear;
  assign drop_s    = push_valid_r && full_s && !pop_s;
  assign next_rd_s = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
  // A push landing exactly on the next head slot must bypass the memory read.
  assign bypass_s  = accept_s && (wr_ptr_r == next_rd_s);

  // Next occupancy, stall and head contents for the registered outputs.
  always_comb begin
    case ({accept_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
    stall_next_s = ((CW'(FIFO_DEPTH) - count_next_s) <= CW'(2));
    if (bypass_s) begin
      head_sum_s = push_sum_r;
      head_idx_s = push_idx_r;
    end else begin
      head_sum_s = mem_sum[next_rd_s];
      head_idx_s = mem_idx[next_rd_s];
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_sum[wr_ptr_r] <= push_sum_r;
      mem_idx[wr_ptr_r] <= push_idx_r;
    end
  end

  // FIFO pointers, occupancy and registered outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      sum_valid <= 1'b0;
      stall     <= 1'b0;
      overflow  <= 1'b0;
      row_sum   <= 32'd0;
      row_index <= 32'd0;
    end else if (clear) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      sum_valid <= 1'b0;
      stall     <= 1'b0;
      overflow  <= 1'b0;
      row_sum   <= 32'd0;
      row_index <= 32'd0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r  <= next_rd_s;
      count_r   <= count_next_s;
      sum_valid <= (count_next_s != CW'(0));
      stall     <= stall_next_s;
      row_sum   <= head_sum_s;
      row_index <= head_idx_s;
      if (drop_s) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
